// File: rtl/ecall_pkg.sv
// ecall_pkg: shared types and constants for the ecall sequencer.
//   ecall_state_t  - sequencer FSM state
//   SVC_*          - a7 service codes (full 32-bit compare)
//   A0_IDX/A7_IDX  - register-file indices of the argument/service registers
package ecall_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrint,
    StWaitIn,
    StWrite,
    StDone,
    StHalt
  } ecall_state_t;

  localparam logic [31:0] SVC_PRINT_INT = 32'd1;
  localparam logic [31:0] SVC_READ_INT  = 32'd5;
  localparam logic [31:0] SVC_EXIT      = 32'd10;

  localparam logic [4:0] A0_IDX = 5'd10;
  localparam logic [4:0] A7_IDX = 5'd17;

endpackage

// File: rtl/ecall_ctrl.sv
// ecall_ctrl: sequences ecall system calls while the ecall sits in decode.
// Stalls the pipeline, dispatches on a7, drives the display / user-input
// handshake and writes read results back to a0.
// Ports:
//   clk, rst              core clock, asynchronous active-low reset
//   ecall_i               decode-stage instruction is ecall (held while stalled)
//   a0_i, a7_i            register-file values of x10 / x17
//   sw_i                  raw board switches, sign-extended on read
//   confirm_i             single-cycle debounced button pulse
//   stall_o               freeze PC and decode/execute registers
//   wb_en_o/rd_o/data_o   register-file write request (wins the write port)
//   disp_o                seven-segment display value
//   wait_in_o             waiting for user input
//   halt_o                program exited, sticky until reset
module ecall_ctrl
  import ecall_pkg::*;
#(
  parameter int unsigned SW_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ecall_i,
  input  logic [31:0]         a0_i,
  input  logic [31:0]         a7_i,
  input  logic [SW_WIDTH-1:0] sw_i,
  input  logic                confirm_i,
  output logic                stall_o,
  output logic                wb_en_o,
  output logic [4:0]          wb_rd_o,
  output logic [31:0]         wb_data_o,
  output logic [31:0]         disp_o,
  output logic                wait_in_o,
  output logic                halt_o
);

  ecall_state_t state_q, state_d;
  logic [31:0]  svc_q, svc_d;
  logic [31:0]  arg_q, arg_d;
  logic [31:0]  data_q, data_d;
  logic [31:0]  disp_q, disp_d;
  logic [31:0]  sw_ext;
  logic         stall_raw;

  assign sw_ext = 32'($signed(sw_i));

  always_comb begin
    state_d   = state_q;
    svc_d     = svc_q;
    arg_d     = arg_q;
    data_d    = data_q;
    disp_d    = disp_q;
    stall_raw = 1'b0;
    wb_en_o   = 1'b0;
    wb_data_o = 32'd0;
    wait_in_o = 1'b0;
    halt_o    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ecall_i) begin
          stall_raw = 1'b1;
          svc_d     = a7_i;
          arg_d     = a0_i;
          if (a7_i == SVC_PRINT_INT) begin
            state_d = StPrint;
            disp_d  = a0_i;
          end else if (a7_i == SVC_READ_INT) begin
            state_d = StWaitIn;
          end else if (a7_i == SVC_EXIT) begin
            state_d = StHalt;
          end else begin
            state_d = StDone;
          end
        end
      end
      StPrint: begin
        stall_raw = 1'b1;
        disp_d    = arg_q;  // display keeps the latched argument
        if (confirm_i) state_d = StDone;
      end
      StWaitIn: begin
        stall_raw = 1'b1;
        wait_in_o = 1'b1;
        if (confirm_i) begin
          data_d  = sw_ext;
          // Only a read service may reach the write-back state.
          state_d = (svc_q == SVC_READ_INT) ? StWrite : StDone;
        end
      end
      StWrite: begin
        stall_raw = 1'b1;
        wb_en_o   = 1'b1;
        wb_data_o = data_q;
        disp_d    = data_q;
        state_d   = StDone;
      end
      StDone: begin
        // Stall released for one cycle so the ecall retires; ecall_i ignored.
        state_d = StIdle;
      end
      StHalt: begin
        stall_raw = 1'b1;
        halt_o    = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Stall is combinational so it lands in the cycle the ecall is first seen.
  assign stall_o = stall_raw & rst;
  assign wb_rd_o = A0_IDX;
  assign disp_o  = disp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      svc_q   <= 32'd0;
      arg_q   <= 32'd0;
      data_q  <= 32'd0;
      disp_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      svc_q   <= svc_d;
      arg_q   <= arg_d;
      data_q  <= data_d;
      disp_q  <= disp_d;
    end
  end

endmodule

// File: tb/tb_ecall_ctrl.sv
// tb_ecall_ctrl: directed scenario tasks plus a randomized run against a
// timeline model built from the service latency rules.
module tb_ecall_ctrl;

  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ecall_i = 1'b0;
  logic          confirm_i = 1'b0;
  logic [31:0]   a0_i = 32'd0;
  logic [31:0]   a7_i = 32'd0;
  logic [SW-1:0] sw_i = '0;
  logic          stall_o, wb_en_o, wait_in_o, halt_o;
  logic [4:0]    wb_rd_o;
  logic [31:0]   wb_data_o, disp_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ecall_ctrl #(.SW_WIDTH(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ecall_i   (ecall_i),
    .a0_i      (a0_i),
    .a7_i      (a7_i),
    .sw_i      (sw_i),
    .confirm_i (confirm_i),
    .stall_o   (stall_o),
    .wb_en_o   (wb_en_o),
    .wb_rd_o   (wb_rd_o),
    .wb_data_o (wb_data_o),
    .disp_o    (disp_o),
    .wait_in_o (wait_in_o),
    .halt_o    (halt_o)
  );

  // {stall, wait_in, halt, wb_en, wb_rd, wb_data, disp}
  function automatic logic [72:0] obs();
    return {stall_o, wait_in_o, halt_o, wb_en_o, wb_rd_o, wb_data_o, disp_o};
  endfunction

  function automatic logic [72:0] expv(input logic st, input logic wi, input logic hl,
                                       input logic we, input logic [31:0] wd,
                                       input logic [31:0] dp);
    return {st, wi, hl, we, 5'd10, wd, dp};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ecall_i = 1'b1;  // stall must be forced low during reset
    a7_i = 32'd1;
    cyc(); #1;
    checks++;
    if (obs() !== expv(0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_hold: got %h exp %h", obs(), expv(0, 0, 0, 0, 0, 0));
    end
    cyc(); rst = 1'b1; ecall_i = 1'b0; #1;
    checks++;
    if (obs() !== expv(0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_idle: got %h exp %h", obs(), expv(0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_print();
    bit bad = 0;
    bit saw_wb = 0;
    cyc(); ecall_i = 1'b1; a7_i = 32'd1; a0_i = 32'hFFFF_FFF6; #1;
    checks++;
    if (stall_o !== 1'b1 || disp_o !== 32'd0) begin
      errors++; $display("FAIL print_dispatch: stall=%b disp=%h exp 1/0", stall_o, disp_o);
    end
    cyc(); #1;
    checks++;
    if (disp_o !== 32'hFFFF_FFF6 || stall_o !== 1'b1) begin
      errors++; $display("FAIL print_disp: disp=%h stall=%b exp fffffff6/1", disp_o, stall_o);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(); #1;
      if (stall_o !== 1'b1 || disp_o !== 32'hFFFF_FFF6) bad = 1;
      if (wb_en_o !== 1'b0) saw_wb = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL print_hold: stall/disp changed, last stall=%b exp 1", stall_o);
    end
    cyc(); confirm_i = 1'b1; #1;
    if (wb_en_o !== 1'b0) saw_wb = 1;
    cyc(); confirm_i = 1'b0; #1;
    checks++;
    if (stall_o !== 1'b0 || disp_o !== 32'hFFFF_FFF6) begin
      errors++; $display("FAIL print_done: stall=%b disp=%h exp 0/fffffff6", stall_o, disp_o);
    end
    if (wb_en_o !== 1'b0) saw_wb = 1;
    cyc(); ecall_i = 1'b0; #1;
    if (wb_en_o !== 1'b0) saw_wb = 1;
    checks++;
    if (saw_wb || stall_o !== 1'b0) begin
      errors++; $display("FAIL print_nowrite: saw_wb=%b stall=%b exp 0/0", saw_wb, stall_o);
    end
  endtask

  task automatic test_read();
    bit bad = 0;
    cyc(); ecall_i = 1'b1; a7_i = 32'd5; a0_i = 32'h1111_2222; sw_i = 16'h8003; #1;
    if (stall_o !== 1'b1 || wait_in_o !== 1'b0) bad = 1;
    for (int c = 1; c <= 5; c++) begin
      cyc(); confirm_i = (c == 5); #1;
      if (stall_o !== 1'b1 || wait_in_o !== 1'b1 || wb_en_o !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL read_wait: stall=%b wait_in=%b exp 1/1", stall_o, wait_in_o);
    end
    cyc(); confirm_i = 1'b0; #1;
    checks++;
    if (obs() !== expv(1, 0, 0, 1, 32'hFFFF_8003, 32'hFFFF_FFF6)) begin
      errors++; $display("FAIL read_write: got %h exp %h", obs(),
                         expv(1, 0, 0, 1, 32'hFFFF_8003, 32'hFFFF_FFF6));
    end
    cyc(); #1;
    checks++;
    if (obs() !== expv(0, 0, 0, 0, 0, 32'hFFFF_8003)) begin
      errors++; $display("FAIL read_done: got %h exp %h", obs(), expv(0, 0, 0, 0, 0, 32'hFFFF_8003));
    end
    cyc(); ecall_i = 1'b0;
  endtask

  task automatic test_early_confirm();
    bit bad = 0;
    cyc(); ecall_i = 1'b1; a7_i = 32'd5; sw_i = 16'h1234; confirm_i = 1'b1; #1;
    for (int c = 1; c <= 6; c++) begin
      cyc(); confirm_i = 1'b0; #1;
      if (wait_in_o !== 1'b1 || wb_en_o !== 1'b0 || stall_o !== 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL early_confirm_wait: wait_in=%b wb_en=%b exp 1/0", wait_in_o, wb_en_o);
    end
    cyc(); confirm_i = 1'b1; #1;
    cyc(); confirm_i = 1'b0; #1;
    checks++;
    if (wb_en_o !== 1'b1 || wb_data_o !== 32'h0000_1234) begin
      errors++; $display("FAIL early_confirm_write: wb_en=%b data=%h exp 1/00001234",
                         wb_en_o, wb_data_o);
    end
    cyc(); #1;
    checks++;
    if (stall_o !== 1'b0 || disp_o !== 32'h0000_1234) begin
      errors++; $display("FAIL early_confirm_done: stall=%b disp=%h exp 0/00001234", stall_o, disp_o);
    end
    cyc(); ecall_i = 1'b0;
  endtask

  task automatic test_exit();
    bit bad = 0;
    cyc(); ecall_i = 1'b1; a7_i = 32'd10; #1;
    checks++;
    if (stall_o !== 1'b1 || halt_o !== 1'b0) begin
      errors++; $display("FAIL exit_dispatch: stall=%b halt=%b exp 1/0", stall_o, halt_o);
    end
    for (int i = 0; i < 50; i++) begin
      cyc(); confirm_i = (i % 7 == 3); #1;
      if (stall_o !== 1'b1 || halt_o !== 1'b1 || wb_en_o !== 1'b0) bad = 1;
    end
    confirm_i = 1'b0;
    checks++;
    if (bad) begin
      errors++; $display("FAIL exit_sticky: stall=%b halt=%b exp 1/1", stall_o, halt_o);
    end
    cyc(); #2; rst = 1'b0; #1;
    checks++;
    if (stall_o !== 1'b0 || halt_o !== 1'b0) begin
      errors++; $display("FAIL exit_reset: stall=%b halt=%b exp 0/0", stall_o, halt_o);
    end
    cyc(); rst = 1'b1; ecall_i = 1'b0;
  endtask

  task automatic test_noop();
    logic [31:0] codes [2] = '{32'd7, 32'h0000_0101};
    for (int k = 0; k < 2; k++) begin
      cyc(); ecall_i = 1'b1; a7_i = codes[k]; #1;
      checks++;
      if (stall_o !== 1'b1) begin
        errors++; $display("FAIL noop_dispatch[%0d]: stall=%b exp 1", k, stall_o);
      end
      cyc(); #1;
      checks++;
      if (stall_o !== 1'b0 || wb_en_o !== 1'b0 || halt_o !== 1'b0) begin
        errors++; $display("FAIL noop_done[%0d]: stall=%b wb_en=%b halt=%b exp 0/0/0",
                           k, stall_o, wb_en_o, halt_o);
      end
      cyc(); ecall_i = 1'b0;
    end
  endtask

  task automatic test_reset_mid_read();
    bit bad = 0;
    // Give disp a nonzero value first so the reset clear is observable.
    cyc(); ecall_i = 1'b1; a7_i = 32'd1; a0_i = 32'hABCD_0001;
    cyc(); confirm_i = 1'b1;
    cyc(); confirm_i = 1'b0;
    cyc(); a7_i = 32'd5; sw_i = 16'h7FFF;
    for (int c = 0; c < 3; c++) cyc();
    #1;
    checks++;
    if (wait_in_o !== 1'b1) begin
      errors++; $display("FAIL midread_wait: wait_in=%b exp 1", wait_in_o);
    end
    #2; rst = 1'b0; #1;
    checks++;
    if (obs() !== expv(0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL midread_reset: got %h exp %h", obs(), expv(0, 0, 0, 0, 0, 0));
    end
    cyc(); rst = 1'b1; ecall_i = 1'b0;
    cyc(); confirm_i = 1'b1; #1;
    if (wb_en_o !== 1'b0 || wait_in_o !== 1'b0) bad = 1;
    for (int c = 0; c < 4; c++) begin
      cyc(); confirm_i = 1'b0; #1;
      if (wb_en_o !== 1'b0 || wait_in_o !== 1'b0 || stall_o !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL midread_nowrite: wb_en=%b wait_in=%b exp 0/0", wb_en_o, wait_in_o);
    end
  endtask

  // Randomized back-to-back ecalls; expected outputs come from the
  // per-service timeline (dispatch, confirm after d cycles, write, retire).
  task automatic test_random();
    logic [31:0] exp_disp;
    logic [72:0] e;
    cyc(); rst = 1'b0; ecall_i = 1'b0; confirm_i = 1'b0;
    cyc(); rst = 1'b1;
    exp_disp = 32'd0;
    for (int t = 0; t < 60; t++) begin
      logic [31:0] code, a0v, ext;
      logic [SW-1:0] swv;
      int d, sel, last;
      bit early, done;
      sel = $urandom_range(0, 4);
      case (sel)
        0: code = 32'd1;
        1: code = 32'd5;
        2: code = 32'd7;
        3: code = 32'h0000_0101;
        default: begin
          code = $urandom;
          if (code == 32'd1 || code == 32'd5 || code == 32'd10) code = 32'd3;
        end
      endcase
      a0v = $urandom;
      swv = SW'($urandom);
      ext = {{(32 - SW){swv[SW-1]}}, swv};
      d = $urandom_range(1, 5);
      early = 1'($urandom_range(0, 1));
      last = (code == 32'd1) ? d + 1 : (code == 32'd5) ? d + 2 : 1;
      done = 0;
      for (int c = 0; !done && c < 16; c++) begin
        cyc();
        ecall_i = 1'b1; a7_i = code; a0_i = a0v; sw_i = swv;
        confirm_i = (c == 0 && early) || (c == d) || (c > d && $urandom_range(0, 2) == 0);
        if (c == 0) e = expv(1, 0, 0, 0, 0, exp_disp);
        else if (code == 32'd1) e = expv(c < last, 0, 0, 0, 0, a0v);
        else if (code == 32'd5) begin
          if (c <= d) e = expv(1, 1, 0, 0, 0, exp_disp);
          else if (c == d + 1) e = expv(1, 0, 0, 1, ext, exp_disp);
          else e = expv(0, 0, 0, 0, 0, ext);
        end else e = expv(0, 0, 0, 0, 0, exp_disp);
        #1;
        checks++;
        if (obs() !== e) begin
          errors++; $display("FAIL rand[%0d] cyc %0d a7=%h: got %h exp %h", t, c, code, obs(), e);
        end
        if (c == last) begin
          done = 1;
          if (code == 32'd1) exp_disp = a0v;
          if (code == 32'd5) exp_disp = ext;
        end
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        cyc(); ecall_i = 1'b0; confirm_i = 1'($urandom_range(0, 1)); #1;
        checks++;
        if (obs() !== expv(0, 0, 0, 0, 0, exp_disp)) begin
          errors++; $display("FAIL rand_gap[%0d]: got %h exp %h", t, obs(),
                             expv(0, 0, 0, 0, 0, exp_disp));
        end
      end
    end
    cyc(); ecall_i = 1'b0; confirm_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_print();
    test_read();
    test_early_confirm();
    test_noop();
    test_exit();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ecall_ctrl.md
# ecall_ctrl

Sequencer for `ecall` system-call instructions in the MiniRiscV core. While an `ecall` occupies the decode stage it stalls the pipeline, selects a service from `a7`, drives the board display and user-input handshake, and writes the result back to `a0` through the register-file write port. Sits beside the decoder/register file; its write request is muxed onto the register write port, and it wins that port whenever it asserts it.

## Interface
- `SW_WIDTH`, 16: width of the board switch input; sign-extended to 32 bits on read.
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ecall_i`  in  1  decode-stage instruction is `ecall` (opcode 7'b1110011); held high while stalled.
- `a0_i`  in  32  current register-file value of x10.
- `a7_i`  in  32  current register-file value of x17.
- `sw_i`  in  `SW_WIDTH`  raw switch value.
- `confirm_i`  in  1  single-cycle pulse from the external button debouncer.
- `stall_o`  out  1  freeze PC and decode/execute pipeline registers.
- `wb_en_o`  out  1  register-write request; overrides pipeline write-back this cycle.
- `wb_rd_o`  out  5  write destination; constant 5'd10.
- `wb_data_o`  out  32  write data.
- `disp_o`  out  32  value for the seven-segment display.
- `wait_in_o`  out  1  waiting for user input (drives input-request LED).
- `halt_o`  out  1  program exited; sticky until reset.

## Operation
- States: IDLE, PRINT, WAIT_IN, WRITE, DONE, HALT.
- IDLE: if `ecall_i`, latch `a7_i` into `svc_q` and `a0_i` into `arg_q`, then dispatch on `a7_i`:
  - 1 (print int) -> PRINT; `disp_o` <= `a0_i`.
  - 5 (read int) -> WAIT_IN.
  - 10 (exit) -> HALT.
  - any other value -> DONE (no-op service, no write).
- PRINT: wait for `confirm_i`, then go to DONE. `disp_o` holds.
- WAIT_IN: `wait_in_o`=1; on `confirm_i`, latch sign-extended `sw_i` into `data_q` and go to WRITE.
- WRITE: `wb_en_o`=1, `wb_data_o`=`data_q` for exactly one cycle; `disp_o` <= `data_q`; go to DONE.
- DONE: `stall_o`=0 for one cycle so the `ecall` retires; `ecall_i` is ignored; go to IDLE.
- HALT: absorbing; `halt_o`=1 and `stall_o`=1 until reset.
- `stall_o` = (`ecall_i` && state==IDLE) || state in {PRINT, WAIT_IN, WRITE, HALT}. It is combinational, so the stall takes effect in the same cycle the `ecall` is first seen.
- `wb_data_o` reads 0 whenever `wb_en_o`=0. `wb_rd_o` is always 10.
- Service code compare uses all 32 bits of `a7`; for example, 32'h0000_0101 is a no-op.

## Timing
- Reset: state=IDLE; `svc_q`, `arg_q`, `data_q`, `disp_o` = 0. `stall_o`, `wb_en_o`, `wait_in_o`, `halt_o` = 0. While `rst` is low, `stall_o` is forced to 0.
- Reset mid-service (any state, including HALT) aborts immediately; no write is issued.
- `confirm_i` is sampled only in PRINT and WAIT_IN. A pulse in the dispatch cycle (IDLE) or in WRITE/DONE is dropped; it is not queued.
- Minimum latencies, counted from the first cycle `ecall_i` is high:
  - no-op: 1 stall cycle, then DONE.
  - print: 1 + N stall cycles, where N is the number of cycles until the confirm pulse.
  - read: confirm at cycle k -> WRITE at k+1 -> DONE at k+2.
- Back-to-back `ecall`: the second one is seen in IDLE after DONE and is dispatched normally.
- `disp_o` is updated only by print and read; it persists across other instructions.

## Structure
- Package `ecall_pkg` holds:
  - state enum `ecall_state_t`;
  - constants `SVC_PRINT_INT`=1, `SVC_READ_INT`=5, `SVC_EXIT`=10, `A0_IDX`=10, `A7_IDX`=17.
- Single module, no sub-modules. Button debouncing and display decoding stay outside this block.

## Test plan
- Reset, then idle: `stall_o`=0, `disp_o`=0, `halt_o`=0.
- Print: `ecall_i`=1, `a7`=1, `a0`=32'hFFFF_FFF6.
  - `stall_o`=1 in the same cycle; `disp_o`=32'hFFFF_FFF6 next cycle.
  - Stall holds for 20 cycles without confirm.
  - After confirm: one DONE cycle with `stall_o`=0; no `wb_en_o` at any point.
- Read: `a7`=5, `sw_i`=16'h8003, confirm pulse at cycle 5.
  - `wb_en_o`=1, `wb_rd_o`=10, `wb_data_o`=32'hFFFF_8003 at cycle 6 only.
  - `stall_o` drops at cycle 7.
- Early confirm: pulse in the same cycle the read `ecall` is dispatched -> ignored; the block stays in WAIT_IN until a second pulse arrives.
- Exit and no-op:
  - `a7`=10 -> `halt_o`=1 and `stall_o`=1 persist 50 cycles; reset clears both.
  - `a7`=7 -> exactly one stall cycle, no write.
- Reset mid-read: assert `rst` low while in WAIT_IN -> all outputs 0 immediately; a confirm after reset release causes no write.
